// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver: configurable data/parity/stop format, 3-sample majority
// voting, line-break detection and a single-word holding register with overrun flag.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] SAMP0    = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] SAMP1    = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] SAMP2    = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PARITY   = 3'd3;
  localparam logic [2:0] S_STOP     = 3'd4;
  localparam logic [2:0] S_BRK_WAIT = 3'd5;

  logic                 rx_p0, rx_p1, rx_p2;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [1:0]           samp;
  logic                 seen_one;
  logic                 ferr_acc;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;

  logic mid, wrap, bit_val, last_stop, brk_now, complete;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
    if (PARITY == 1) return ~(^d ^ p);
    else if (PARITY == 2) return ^d ^ p;
    else return 1'b0;
  endfunction

  assign mid       = baud_tick && (cnt == SAMP2);
  assign wrap      = baud_tick && (cnt == CNT_LAST);
  assign bit_val   = majority3(samp[0], samp[1], rx_p1);
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  // A break ends the frame at the first stop bit even when two are configured.
  assign brk_now   = !stop_cnt && !seen_one && !bit_val;
  assign complete  = (state == S_STOP) && mid && (brk_now || last_stop);
  assign busy      = (state != S_IDLE);

  // Stage p0/p1: line synchroniser; p2 keeps the previous value for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_p0    <= 1'b1;
      rx_p1    <= 1'b1;
      rx_p2    <= 1'b1;
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      samp     <= 2'b11;
      seen_one <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
      if (baud_tick && state != S_IDLE && state != S_BRK_WAIT) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == SAMP0) samp[0] <= rx_p1;
        if (cnt == SAMP1) samp[1] <= rx_p1;
      end
      case (state)
        S_IDLE:
          if (rx_p2 && !rx_p1) begin
            state    <= S_START;
            cnt      <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            seen_one <= 1'b0;
            ferr_acc <= 1'b0;
          end
        S_START:
          if (mid && bit_val) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (wrap) begin
            state <= S_DATA;
          end
        S_DATA: begin
          if (mid) seen_one <= seen_one | bit_val;
          if (wrap) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (mid) seen_one <= seen_one | bit_val;
          if (wrap) state <= S_STOP;
        end
        S_STOP:
          if (mid) begin
            if (brk_now) begin
              state <= S_BRK_WAIT;
              cnt   <= '0;
            end else if (last_stop) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
              if (!bit_val) ferr_acc <= 1'b1;
            end
          end
        S_BRK_WAIT:
          if (rx_p1) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DATA && mid) shift <= {bit_val, shift[DATA_BITS-1:1]};
    if (state == S_PARITY && mid) par_bit <= bit_val;
  end

  // Holding register: a completed frame is dropped only if the old word is not leaving.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete && data_valid && !data_ready) begin
        overrun <= 1'b1;
      end else if (complete) begin
        data_out   <= shift;
        parity_err <= parity_error(shift, par_bit);
        frame_err  <= brk_now | ferr_acc | ~bit_val;
        break_det  <= brk_now;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and an 8E1 receiver driven with directed and random
// frames, checked every cycle against queues of expected words built from frame rules.
module tb_uart_rx_cfg;
  localparam int OS = 16;

  logic       clk;
  logic       reset_n;
  logic       baud_tick;
  logic       data_ready;
  logic       rx_n, rx_e;
  logic [7:0] dout_n, dout_e;
  logic       dv_n, pe_n, fe_n, bk_n, ov_n, busy_n;
  logic       dv_e, pe_e, fe_e, bk_e, ov_e, busy_e;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } word_t;

  word_t q0[$];
  word_t q1[$];
  int    exp_ovr[2];
  int    obs_ovr[2];
  int    checks   = 0;
  int    failures = 0;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx_n),
    .data_out(dout_n), .data_valid(dv_n), .data_ready(data_ready),
    .parity_err(pe_n), .frame_err(fe_n), .break_det(bk_n), .overrun(ov_n), .busy(busy_n));

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx_e),
    .data_out(dout_e), .data_valid(dv_e), .data_ready(data_ready),
    .parity_err(pe_e), .frame_err(fe_e), .break_det(bk_e), .overrun(ov_e), .busy(busy_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Irregular baud ticks so gaps in baud_tick are exercised throughout.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1 baud_tick = ($urandom_range(0, 2) != 0);
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Expected outcome of one frame: even parity on instance 1, none on instance 0.
  function automatic word_t expect_word(input int inst, input logic [7:0] d,
                                        input logic pbit, input logic stopb);
    word_t w;
    w.d  = d;
    w.pe = (inst == 1) && ((^d) != pbit);
    w.bk = (d == 8'h00) && (inst == 0 || !pbit) && !stopb;
    w.fe = !stopb;
    return w;
  endfunction

  function automatic int qsize(input int inst);
    return (inst == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void compare_inst(input int inst, input logic [7:0] d, input logic dv,
                                       input logic pe, input logic fe, input logic bk,
                                       input logic ov);
    word_t w;
    if (ov) obs_ovr[inst]++;
    if (dv) begin
      check($sformatf("valid_has_word_%0d", inst), qsize(inst) > 0, 1);
      if (qsize(inst) > 0) begin
        w = (inst == 0) ? q0[0] : q1[0];
        check($sformatf("held_word_%0d", inst), {d, pe, fe, bk}, {w.d, w.pe, w.fe, w.bk});
        if (data_ready) begin
          if (inst == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_outputs_0", {dout_n, dv_n, pe_n, fe_n, bk_n, ov_n, busy_n}, 0);
      check("reset_outputs_1", {dout_e, dv_e, pe_e, fe_e, bk_e, ov_e, busy_e}, 0);
    end else begin
      compare_inst(0, dout_n, dv_n, pe_n, fe_n, bk_n, ov_n);
      compare_inst(1, dout_e, dv_e, pe_e, fe_e, bk_e, ov_e);
    end
  end

  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) rx_n = v;
    else rx_e = v;
  endtask

  task automatic hold_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge clk);
      if (baud_tick) k++;
    end
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d, input logic pbit,
                            input logic stopb, input bit drop);
    if (drop) exp_ovr[inst]++;
    else if (inst == 0) q0.push_back(expect_word(inst, d, pbit, stopb));
    else q1.push_back(expect_word(inst, d, pbit, stopb));
    set_rx(inst, 1'b0);
    hold_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      set_rx(inst, d[i]);
      hold_ticks(OS);
    end
    if (inst == 1) begin
      set_rx(inst, pbit);
      hold_ticks(OS);
    end
    set_rx(inst, stopb);
    hold_ticks(OS);
    set_rx(inst, 1'b1);
  endtask

  task automatic wait_valid(input int inst, input string name);
    int n = 0;
    while (((inst == 0) ? dv_n : dv_e) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, (inst == 0) ? dv_n : dv_e, 1);
  endtask

  task automatic accept();
    @(posedge clk);
    #1 data_ready = 1'b1;
    @(posedge clk);
    #1 data_ready = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int         inst;
    logic [7:0] d;
    logic       pb, sb;
    bit         hold;
    int         ovr_base;
    logic [7:0] b3c;

    exp_ovr    = '{0, 0};
    obs_ovr    = '{0, 0};
    rx_n       = 1'b1;
    rx_e       = 1'b1;
    data_ready = 1'b0;
    reset_n    = 1'b1;
    #1 reset_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_busy_0", busy_n, 0);
    check("reset_valid_1", dv_e, 0);
    reset_n = 1'b1;
    hold_ticks(4);

    // 8N1 word held until accepted
    send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
    wait_valid(0, "valid_a5");
    check("a5_data", dout_n, 8'hA5);
    check("a5_flags", {pe_n, fe_n, bk_n}, 3'b000);
    repeat (40) @(negedge clk);
    check("a5_still_valid", dv_n, 1);
    check("a5_still_data", dout_n, 8'hA5);
    accept();
    repeat (2) @(negedge clk);
    check("a5_released", dv_n, 0);

    // even parity, wrong parity bit
    hold_ticks(4);
    send_frame(1, 8'h07, 1'b0, 1'b1, 0);
    wait_valid(1, "valid_07");
    check("p07_data", dout_e, 8'h07);
    check("p07_parity_err", pe_e, 1);
    check("p07_frame_err", fe_e, 0);
    accept();

    // 3-tick glitch is a false start
    hold_ticks(4);
    rx_n = 1'b0;
    hold_ticks(3);
    rx_n = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", busy_n, 1);
    hold_ticks(2 * OS);
    check("glitch_idle", busy_n, 0);
    check("glitch_no_valid", dv_n, 0);

    // back-to-back frames with no consumer
    ovr_base = obs_ovr[0];
    hold_ticks(4);
    send_frame(0, 8'h11, 1'b0, 1'b1, 0);
    hold_ticks(2);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1);
    repeat (2) @(negedge clk);
    check("ovr_pulses", obs_ovr[0] - ovr_base, 1);
    check("ovr_kept_data", dout_n, 8'h11);
    accept();
    hold_ticks(4 * OS);
    check("ovr_no_second_word", dv_n, 0);

    // line break: low for two frame times
    hold_ticks(4);
    q0.push_back(expect_word(0, 8'h00, 1'b0, 1'b0));
    rx_n = 1'b0;
    hold_ticks(11 * OS);
    check("brk_valid", dv_n, 1);
    check("brk_word", {dout_n, pe_n, fe_n, bk_n}, {8'h00, 3'b011});
    accept();
    hold_ticks(9 * OS);
    check("brk_waiting", busy_n, 1);
    check("brk_no_new_frame", dv_n, 0);
    rx_n = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_released", busy_n, 0);

    // reset during data bit 4 while an older word is still held
    hold_ticks(4);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 0);
    wait_valid(0, "valid_5a");
    b3c = 8'h3C;
    hold_ticks(4);
    rx_n = 1'b0;
    hold_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx_n = b3c[i];
      hold_ticks(OS);
    end
    rx_n = b3c[4];
    hold_ticks(OS / 2);
    #2 reset_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check("rst_async_valid", dv_n, 0);
    check("rst_async_data", dout_n, 0);
    check("rst_async_busy", busy_n, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rx_n = 1'b1;
    hold_ticks(3 * OS);
    check("rst_abandoned", {dv_n, busy_n}, 2'b00);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 0);
    wait_valid(0, "valid_3c");
    check("rst_3c_data", dout_n, 8'h3C);
    accept();

    // random frames on both receivers
    for (int i = 0; i < 30; i++) begin
      inst = $urandom_range(0, 1);
      d    = 8'($urandom);
      pb   = (^d) ^ ($urandom_range(0, 3) == 0);
      sb   = ($urandom_range(0, 7) != 0);
      hold = ($urandom_range(0, 1) == 1);
      @(posedge clk);
      #1 data_ready = !hold;
      hold_ticks($urandom_range(2, 20));
      send_frame(inst, d, pb, sb, 0);
      if (hold) begin
        wait_valid(inst, "rand_valid");
        repeat ($urandom_range(0, 15)) @(posedge clk);
        accept();
      end
      repeat (3) @(negedge clk);
      check("rand_delivered", qsize(inst), 0);
      @(posedge clk);
      #1 data_ready = 1'b0;
    end

    repeat (5) @(negedge clk);
    check("final_queue_0", q0.size(), 0);
    check("final_queue_1", q1.size(), 0);
    check("overrun_count_0", obs_ovr[0], exp_ovr[0]);
    check("overrun_count_1", obs_ovr[1], exp_ovr[1]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
